// File: rtl/entry_interface_arbiter_if.sv
// Entry-interface bundle: per-interface request/code in,
// one-hot grant, grant index and timeout pulse out.
interface entry_interface_arbiter_if #(
  parameter int NCH   = 4,
  parameter int CODEW = 3
);
  localparam int IDW = $clog2(NCH);

  logic [NCH-1:0]       req;
  logic [NCH*CODEW-1:0] code;
  logic [NCH-1:0]       gnt;
  logic                 gnt_valid;
  logic [IDW-1:0]       gnt_id;
  logic                 timeout;

  modport master (
    output req, code,
    input  gnt, gnt_valid, gnt_id, timeout
  );

  modport slave (
    input  req, code,
    output gnt, gnt_valid, gnt_id, timeout
  );
endinterface

// File: rtl/entry_interface_arbiter.sv
// Highest-code arbiter over NCH entry interfaces with round-robin
// tie-break, bounded hold time and per-interface timeout blocking.
module entry_interface_arbiter #(
  parameter int NCH     = 4,
  parameter int CODEW   = 3,
  parameter int TIMEOUT = 15
) (
  input logic i_clk,
  input logic i_rst,
  entry_interface_arbiter_if.slave bus
);
  localparam int IDW  = $clog2(NCH);
  localparam int CNTW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t          r_state, w_state_nx;
  logic [NCH-1:0]  r_gnt, w_gnt_nx;
  logic            r_gnt_valid, w_gnt_valid_nx;
  logic [IDW-1:0]  r_gnt_id, w_gnt_id_nx;
  logic [IDW-1:0]  r_last, w_last_nx;
  logic [NCH-1:0]  r_blocked, w_blocked_nx;
  logic [CNTW-1:0] r_cnt, w_cnt_nx;
  logic            r_timeout, w_timeout_nx;

  logic [CODEW-1:0] w_code [NCH];
  logic [NCH-1:0]   w_elig;
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_idx;
  logic [CODEW-1:0] w_best;

  for (genvar g = 0; g < NCH; g++) begin : g_code
    assign w_code[g] = bus.code[g*CODEW +: CODEW];
  end

  assign w_elig = bus.req & ~r_blocked;

  // Scan in round-robin order; strict > keeps the earliest of equal codes.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_best  = '0;
    w_idx   = '0;
    for (int off = 1; off <= NCH; off++) begin
      w_idx = IDW'((int'(r_last) + off) % NCH);
      if (w_elig[w_idx] &&
          (!w_found || w_code[w_idx] > w_best)) begin
        w_found = 1'b1;
        w_win   = w_idx;
        w_best  = w_code[w_idx];
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_gnt_id_nx  = r_gnt_id;
    w_last_nx    = r_last;
    w_cnt_nx     = r_cnt;
    w_timeout_nx = 1'b0;
    w_blocked_nx = r_blocked & bus.req;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nx    = NCH'(1) << w_win;
          w_gnt_id_nx = w_win;
          w_last_nx   = w_win;
          w_cnt_nx    = CNTW'(1);
          w_state_nx  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!bus.req[r_gnt_id]) begin
          w_gnt_nx   = '0;
          w_state_nx = S_GAP;
        end else if (r_cnt == CNTW'(TIMEOUT)) begin
          w_gnt_nx               = '0;
          w_blocked_nx[r_gnt_id] = 1'b1;
          w_timeout_nx           = 1'b1;
          w_state_nx             = S_GAP;
        end else begin
          w_cnt_nx = r_cnt + CNTW'(1);
        end
      end
      S_GAP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    w_gnt_valid_nx = |w_gnt_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_id    <= '0;
      r_last      <= IDW'(NCH - 1);
      r_blocked   <= '0;
      r_cnt       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_gnt       <= w_gnt_nx;
      r_gnt_valid <= w_gnt_valid_nx;
      r_gnt_id    <= w_gnt_id_nx;
      r_last      <= w_last_nx;
      r_blocked   <= w_blocked_nx;
      r_cnt       <= w_cnt_nx;
      r_timeout   <= w_timeout_nx;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.timeout   = r_timeout;
endmodule

// File: tb/tb_entry_interface_arbiter.sv
// Scoreboard bench: stimulus queues expected grant episodes,
// a negedge monitor measures each episode and compares.
module tb_entry_interface_arbiter;
  localparam int NCH   = 4;
  localparam int CODEW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  entry_interface_arbiter_if #(.NCH(NCH), .CODEW(CODEW)) bus ();

  entry_interface_arbiter #(
    .NCH(NCH),
    .CODEW(CODEW),
    .TIMEOUT(4)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  typedef struct {
    int id;
    int len;
    int to;
    int gap;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endfunction

  function automatic void push(int id, int len, int to, int gap);
    exp_t e;
    e.id  = id;
    e.len = len;
    e.to  = to;
    e.gap = gap;
    q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_code(int i, int v);
    bus.code[i*CODEW +: CODEW] = CODEW'(v);
  endtask

  // Monitor: one episode = contiguous run of gnt_valid.
  bit   m_in   = 1'b0;
  bit   m_have = 1'b0;
  int   m_len  = 0;
  int   m_dead = 0;
  int   m_id   = 0;
  int   m_to   = 0;
  exp_t m_exp;

  always @(negedge clk) begin
    m_to = (bus.timeout === 1'b1) ? 1 : 0;
    if (bus.gnt_valid === 1'b1) begin
      if (!m_in) begin
        m_in  = 1'b1;
        m_len = 1;
        m_id  = int'(bus.gnt_id);
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_grant: got id %0d want none", m_id);
        end else begin
          m_exp  = q.pop_front();
          m_have = 1'b1;
          chk("grant_id", m_id, m_exp.id);
          if (m_exp.gap >= 0) chk("grant_gap", m_dead, m_exp.gap);
        end
      end else begin
        m_len++;
      end
      chk("gnt_onehot", 32'(bus.gnt), 32'(1) << bus.gnt_id);
      if (m_to != 0) chk("timeout_in_grant", m_to, 0);
    end else if (m_in) begin
      m_in   = 1'b0;
      m_dead = 1;
      if (m_have) begin
        chk("grant_len", m_len, m_exp.len);
        chk("timeout_pulse", m_to, m_exp.to);
        m_have = 1'b0;
      end
    end else begin
      m_dead++;
      if (m_to != 0) chk("timeout_stray", m_to, 0);
    end
  end

  initial begin
    bus.req  = 4'b1111;
    bus.code = '0;

    // reset held with all requests active
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_out",
          {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout}, 0);
    end
    push(0, 1, 0, -1);
    rst = 1'b0;
    tick();
    bus.req = 4'b0000;
    repeat (4) tick();

    // code priority, code change during grant ignored
    set_code(0, 5);
    set_code(1, 2);
    bus.req = 4'b0011;
    push(0, 3, 0, -1);
    tick();
    set_code(1, 7);
    tick();
    tick();
    bus.req = 4'b0000;
    repeat (4) tick();

    // round-robin tie between 1 and 2
    set_code(0, 0);
    set_code(1, 7);
    set_code(2, 7);
    set_code(3, 0);
    push(1, 2, 0, -1);
    push(2, 2, 0, 2);
    push(1, 2, 0, 2);
    push(2, 2, 0, 2);
    bus.req = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      int id;
      id = (k % 2 == 0) ? 1 : 2;
      tick();
      tick();
      bus.req[id] = 1'b0;
      tick();
      if (k < 3) bus.req[id] = 1'b1;
      else bus.req = 4'b0000;
      tick();
    end
    repeat (3) tick();
    chk("gnt_id_hold", {bus.gnt_valid, bus.gnt_id}, {1'b0, 2'd2});

    // timeout, block while held, regrant after a req drop
    bus.code = '0;
    push(3, 4, 1, -1);
    push(3, 2, 0, 9);
    bus.req = 4'b1000;
    repeat (12) tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b1000;
    tick();
    tick();
    bus.req = 4'b0000;
    repeat (4) tick();

    // release on the same edge as the timeout condition
    push(0, 4, 0, -1);
    push(0, 1, 0, 2);
    bus.req = 4'b0001;
    repeat (4) tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0001;
    tick();
    tick();
    bus.req = 4'b0000;
    repeat (4) tick();

    // reset on the second grant cycle
    push(1, 2, 0, -1);
    push(0, 1, 0, 1);
    bus.req = 4'b1111;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("reset_mid_grant",
        {bus.gnt, bus.gnt_valid, bus.gnt_id, bus.timeout}, 0);
    rst = 1'b0;
    tick();
    bus.req = 4'b0000;
    repeat (5) tick();

    chk("queue_empty", q.size(), 0);
    chk("grant_closed", 32'(m_in), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
